// File: rtl/mac_col_acc.sv
// Attention-array MAC column: holds a stationary key, forwards the query, and sums signed
// dot products over acc_len execute beats. Define MAC_COL_ACC_SAT_EN to clamp the result.
module mac_col_acc #(
   parameter int unsigned BW      = 8,
   parameter int unsigned PR      = 8,
   parameter int unsigned NCOL    = 8,
   parameter int unsigned COL_ID  = 1,
   parameter int unsigned BW_PSUM = 2*BW+4,
   parameter int unsigned ACC_W   = 4,
   parameter int unsigned BW_OUT  = 2*BW+4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        i_inst,
   input  logic [ACC_W-1:0]  acc_len,
   input  logic [PR*BW-1:0]  q_in,
   output logic [PR*BW-1:0]  q_out,
   output logic [1:0]        o_inst,
   output logic [BW_OUT-1:0] out,
   output logic              out_valid,
   output logic              key_loaded
);

   localparam int unsigned CNT_W = $clog2(NCOL + 1);
   localparam int unsigned AW    = BW_PSUM + ACC_W;
   localparam int unsigned LW    = ACC_W + 1;
   localparam int unsigned PW    = 2 * BW;
   localparam logic [CNT_W-1:0] KEY_CNT = CNT_W'(NCOL + 1 - COL_ID);

   logic [1:0]              r_inst;
   logic [1:0]              r_inst2;
   logic [PR*BW-1:0]        r_query;
   logic [PR*BW-1:0]        r_key;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_load_ready;
   logic                    r_key_loaded;
   logic [ACC_W-1:0]        r_beat;
   logic [ACC_W-1:0]        r_len;
   logic signed [AW-1:0]    r_acc;
   logic [BW_OUT-1:0]       r_out;
   logic                    r_out_valid;

   logic signed [PW-1:0]      w_qa;
   logic signed [PW-1:0]      w_ka;
   logic signed [BW_PSUM-1:0] w_psum;
   logic                      w_exec;
   logic [ACC_W-1:0]          w_len_sel;
   logic [LW-1:0]             w_len;
   logic                      w_last;
   logic signed [AW-1:0]      w_sum;
   logic [BW_OUT-1:0]         w_res;

   assign q_out      = r_query;
   assign o_inst     = r_inst;
   assign out        = r_out;
   assign out_valid  = r_out_valid;
   assign key_loaded = r_key_loaded;

   // Signed lane-wise dot product of the held query against the stationary key
   always_comb begin
      w_psum = '0;
      w_qa   = '0;
      w_ka   = '0;
      for (int i = 0; i < int'(PR); i++) begin
         w_qa   = PW'($signed(r_query[i*BW +: BW]));
         w_ka   = PW'($signed(r_key[i*BW +: BW]));
         w_psum = w_psum + BW_PSUM'(w_qa * w_ka);
      end
   end

   // First beat of a group takes the length from acc_len; later beats use the latched copy
   always_comb begin
      w_exec    = (r_inst2 == 2'b10);
      w_len_sel = (r_beat == '0) ? acc_len : r_len;
      w_len     = (w_len_sel == '0) ? {1'b1, {ACC_W{1'b0}}} : {1'b0, w_len_sel};
      w_last    = (({1'b0, r_beat}) + LW'(1)) == w_len;
      w_sum     = (r_beat == '0) ? AW'(w_psum) : r_acc + AW'(w_psum);
   end

`ifdef MAC_COL_ACC_SAT_EN
   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-BW_OUT+1){1'b0}}, {(BW_OUT-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-BW_OUT+1){1'b1}}, {(BW_OUT-1){1'b0}}};

   always_comb begin
      w_res = w_sum[BW_OUT-1:0];
      if (w_sum > SAT_MAX)      w_res = SAT_MAX[BW_OUT-1:0];
      else if (w_sum < SAT_MIN) w_res = SAT_MIN[BW_OUT-1:0];
   end
`else
   assign w_res = w_sum[BW_OUT-1:0];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_inst       <= '0;
         r_inst2      <= '0;
         r_query      <= '0;
         r_key        <= '0;
         r_cnt        <= '0;
         r_load_ready <= 1'b1;
         r_key_loaded <= 1'b0;
         r_beat       <= '0;
         r_len        <= '0;
         r_acc        <= '0;
         r_out        <= '0;
         r_out_valid  <= 1'b0;
      end else begin
         r_inst      <= i_inst;
         r_inst2     <= r_inst;
         r_out_valid <= 1'b0;

         // Load window: key is taken on the beat matching this column's skew
         if (r_inst[0]) begin
            r_query <= q_in;
            if (!r_inst2[0])
               r_key_loaded <= 1'b0;
            if (r_load_ready) begin
               if (r_cnt == KEY_CNT) begin
                  r_key        <= q_in;
                  r_cnt        <= '0;
                  r_load_ready <= 1'b0;
                  r_key_loaded <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
         end else begin
            r_load_ready <= 1'b1;
            r_cnt        <= '0;
            if (r_inst[1])
               r_query <= q_in;
         end

         if (w_exec) begin
            if (r_beat == '0)
               r_len <= acc_len;
            r_acc <= w_sum;
            if (w_last) begin
               r_out       <= w_res;
               r_out_valid <= 1'b1;
               r_beat      <= '0;
            end else begin
               r_beat <= r_beat + ACC_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mac_col_acc.sv
// Directed bench for mac_col_acc (COL_ID=3 of 8): transaction-level model predicts every
// output per cycle; literal checks pin the headline results.
module tb_mac_col_acc;

   localparam int unsigned NCOL   = 8;
   localparam int unsigned COL_ID = 3;

   logic        clk;
   logic        reset;
   logic [1:0]  i_inst;
   logic [3:0]  acc_len;
   logic [63:0] q_in;
   logic [63:0] q_out;
   logic [1:0]  o_inst;
   logic [19:0] out;
   logic        out_valid;
   logic        key_loaded;

   mac_col_acc #(
      .BW(8), .PR(8), .NCOL(NCOL), .COL_ID(COL_ID),
      .BW_PSUM(20), .ACC_W(4), .BW_OUT(20)
   ) dut (
      .clk(clk), .reset(reset), .i_inst(i_inst), .acc_len(acc_len),
      .q_in(q_in), .q_out(q_out), .o_inst(o_inst), .out(out),
      .out_valid(out_valid), .key_loaded(key_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Expected output changes, indexed by the clock edge after which they appear
   typedef struct {
      bit          set_oinst;
      logic [1:0]  oinst;
      bit          set_q;
      logic [63:0] q;
      bit          set_kl;
      bit          kl;
      bit          set_out;
      logic [19:0] outv;
      bit          valid;
   } exp_t;
   exp_t ring[8];

   logic [1:0]  cur_oinst = '0;
   logic [63:0] cur_q     = '0;
   bit          cur_kl    = 1'b0;
   logic [19:0] cur_out   = '0;

   // Model state
   logic [63:0] m_key;
   bit          m_prev_load;
   int          m_wcnt;
   bit          m_cap;
   int          m_gbeat;
   int          m_len;
   int          m_acc;
   logic [63:0] prev_data;
   int          g_len;

   int          n_cmp   = 0;
   int          n_err   = 0;
   int          n_pulse = 0;
   logic [19:0] last_out = '0;

   function automatic exp_t zero_e();
      exp_t z;
      z.set_oinst = 0; z.oinst = '0; z.set_q = 0; z.q = '0;
      z.set_kl = 0; z.kl = 0; z.set_out = 0; z.outv = '0; z.valid = 0;
      return z;
   endfunction

   function automatic exp_t reset_e();
      exp_t z;
      z = zero_e();
      z.set_oinst = 1; z.set_q = 1; z.set_kl = 1; z.set_out = 1;
      return z;
   endfunction

   function automatic logic [63:0] lanes(input int v);
      logic [7:0] b;
      b = 8'(v);
      return {8{b}};
   endfunction

   function automatic int dot(input logic [63:0] a, input logic [63:0] b);
      int s;
      s = 0;
      for (int i = 0; i < 8; i++)
         s += int'($signed(a[i*8 +: 8])) * int'($signed(b[i*8 +: 8]));
      return s;
   endfunction

   function automatic logic [19:0] clip(input int v);
`ifdef MAC_COL_ACC_SAT_EN
      if (v > 524287)  return 20'h7FFFF;
      if (v < -524288) return 20'h80000;
`endif
      return 20'(v);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of all DUT outputs against the model
   task automatic check_cycle();
      int  e;
      bit  exp_v;
      e = edge_cnt % 8;
      if (ring[e].set_oinst) cur_oinst = ring[e].oinst;
      if (ring[e].set_q)     cur_q     = ring[e].q;
      if (ring[e].set_kl)    cur_kl    = ring[e].kl;
      if (ring[e].set_out)   cur_out   = ring[e].outv;
      exp_v   = ring[e].valid;
      ring[e] = zero_e();
      chk("o_inst",     64'(o_inst),     64'(cur_oinst));
      chk("q_out",      q_out,           cur_q);
      chk("key_loaded", 64'(key_loaded), 64'(cur_kl));
      chk("out_valid",  64'(out_valid),  64'(exp_v));
      chk("out",        64'(out),        64'(cur_out));
      if (out_valid === 1'b1) begin
         n_pulse++;
         last_out = out;
      end
   endtask

   task automatic step(input logic [1:0] inst, input logic [63:0] data);
      int n;
      int p;
      @(posedge clk); #1;
      n         = edge_cnt;
      reset     = 1'b0;
      i_inst    = inst;
      q_in      = prev_data;
      acc_len   = 4'(g_len);
      prev_data = data;

      ring[(n+1)%8].set_oinst = 1;
      ring[(n+1)%8].oinst     = inst;
      if (inst != 2'b00) begin
         ring[(n+2)%8].set_q = 1;
         ring[(n+2)%8].q     = data;
      end

      if (inst[0]) begin
         if (!m_prev_load) begin
            m_wcnt = 0;
            m_cap  = 0;
            ring[(n+2)%8].set_kl = 1;
            ring[(n+2)%8].kl     = 0;
         end
         m_wcnt++;
         if (!m_cap && m_wcnt == int'(NCOL + 2 - COL_ID)) begin
            m_key = data;
            m_cap = 1;
            ring[(n+2)%8].set_kl = 1;
            ring[(n+2)%8].kl     = 1;
         end
      end
      m_prev_load = inst[0];

      if (inst == 2'b10) begin
         p = dot(data, m_key);
         if (m_gbeat == 0) begin
            m_len = (g_len == 0) ? 16 : g_len;
            m_acc = p;
         end else begin
            m_acc += p;
         end
         m_gbeat++;
         if (m_gbeat == m_len) begin
            ring[(n+3)%8].set_out = 1;
            ring[(n+3)%8].outv    = clip(m_acc);
            ring[(n+3)%8].valid   = 1;
            m_gbeat = 0;
         end
      end

      @(negedge clk);
      check_cycle();
   endtask

   task automatic rst_step();
      int n;
      @(posedge clk); #1;
      n         = edge_cnt;
      reset     = 1'b1;
      i_inst    = 2'b00;
      q_in      = '0;
      prev_data = '0;
      ring[(n+1)%8] = reset_e();
      ring[(n+2)%8] = zero_e();
      ring[(n+3)%8] = zero_e();
      m_key = '0; m_prev_load = 0; m_wcnt = 0; m_cap = 0;
      m_gbeat = 0; m_acc = 0; m_len = 1;
      @(negedge clk);
      check_cycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(2'b00, 64'h0);
   endtask

   task automatic load_const(input int v);
      for (int k = 1; k <= 8; k++) step(2'b01, lanes(v));
      idle(2);
   endtask

   initial begin
      int p0;
      reset = 1'b1; i_inst = 2'b00; q_in = '0; acc_len = 4'd1;
      g_len = 1; prev_data = '0;
      m_key = '0; m_prev_load = 0; m_wcnt = 0; m_cap = 0;
      m_gbeat = 0; m_len = 1; m_acc = 0;
      for (int i = 0; i < 8; i++) ring[i] = zero_e();
      ring[1] = reset_e();

      // Reset held two cycles, then idle
      rst_step();
      idle(4);

      // Two load windows with ramping data; key taken on beat 7
      for (int k = 1; k <= 8; k++) step(2'b01, lanes(k));
      idle(2);
      chk("model_key_win1", m_key, 64'h0707070707070707);
      for (int k = 1; k <= 8; k++) step(2'b01, lanes(k + 10));
      idle(2);
      chk("model_key_win2", m_key, 64'h1111111111111111);
      p0 = n_pulse;
      g_len = 1;
      step(2'b10, lanes(1));
      idle(5);
      chk("key17_out", 64'(last_out), 64'd136);
      chk("key17_pulses", 64'(n_pulse - p0), 64'd1);

      // Single beat: key 2, query 3
      load_const(2);
      p0 = n_pulse;
      step(2'b10, lanes(3));
      idle(5);
      chk("single_out", 64'(last_out), 64'd48);
      chk("single_pulses", 64'(n_pulse - p0), 64'd1);

      // Four-beat group with a gap; acc_len changed mid-group
      g_len = 4;
      p0 = n_pulse;
      step(2'b10, lanes(1));
      step(2'b10, lanes(2));
      idle(1);
      g_len = 1;
      idle(1);
      step(2'b10, lanes(3));
      step(2'b10, lanes(4));
      idle(5);
      chk("acc4_out", 64'(last_out), 64'd160);
      chk("acc4_pulses", 64'(n_pulse - p0), 64'd1);

      // Load+execute beat inside a group does not accumulate
      g_len = 2;
      p0 = n_pulse;
      step(2'b10, lanes(1));
      step(2'b11, lanes(5));
      step(2'b10, lanes(3));
      idle(5);
      chk("inst11_out", 64'(last_out), 64'd64);
      chk("inst11_pulses", 64'(n_pulse - p0), 64'd1);

      // Back-to-back groups of two
      p0 = n_pulse;
      step(2'b10, lanes(1));
      step(2'b10, lanes(1));
      step(2'b10, lanes(3));
      step(2'b10, lanes(3));
      idle(5);
      chk("b2b_out", 64'(last_out), 64'd96);
      chk("b2b_pulses", 64'(n_pulse - p0), 64'd2);

      // Overflow of the output width
      load_const(-128);
      g_len = 8;
      idle(1);
      p0 = n_pulse;
      for (int k = 0; k < 8; k++) step(2'b10, lanes(-128));
      idle(5);
`ifdef MAC_COL_ACC_SAT_EN
      chk("ovf_out", 64'(last_out), 64'h7FFFF);
`else
      chk("ovf_out", 64'(last_out), 64'h0);
`endif
      chk("ovf_pulses", 64'(n_pulse - p0), 64'd1);

      // acc_len=0 means 16 beats
      g_len = 0;
      idle(1);
      p0 = n_pulse;
      for (int k = 0; k < 16; k++) step(2'b10, lanes(1));
      idle(5);
      chk("len16_out", 64'(last_out), 64'hFC000);
      chk("len16_pulses", 64'(n_pulse - p0), 64'd1);

      // Reset in the middle of a group
      g_len = 4;
      idle(1);
      p0 = n_pulse;
      step(2'b10, lanes(1));
      step(2'b10, lanes(1));
      idle(3);
      rst_step();
      rst_step();
      idle(3);
      chk("rstmid_pulses", 64'(n_pulse - p0), 64'd0);

      // Execute with no key yields zero, then a fresh group after reloading
      g_len = 1;
      idle(1);
      p0 = n_pulse;
      step(2'b10, lanes(3));
      idle(5);
      chk("nokey_out", 64'(last_out), 64'd0);
      chk("nokey_pulses", 64'(n_pulse - p0), 64'd1);
      load_const(2);
      p0 = n_pulse;
      step(2'b10, lanes(3));
      idle(5);
      chk("fresh_out", 64'(last_out), 64'd48);
      chk("fresh_pulses", 64'(n_pulse - p0), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
